// File: rtl/bayes_pkg.sv
// Shared types and constants for the stochastic Bayesian engine.
package bayes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] W_PRIOR  = 2'd0;
  localparam logic [1:0] W_LIK_H  = 2'd1;
  localparam logic [1:0] W_LIK_NH = 2'd2;

  localparam int LFSR_W = 24;
  // Taps 24,23,22,17 (1-based) of a maximal-length Fibonacci LFSR.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 24'hE10000;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 24'h5A3C96;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bayes_lfsr24.sv
// 24-bit Fibonacci LFSR; load has priority over advance.
module bayes_lfsr24
  import bayes_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (en) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= RESET_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bayes_stoch_engine.sv
// Fetches prior and two likelihoods from the weight SRAM, then runs a
// stochastic pass producing numerator/alternative event counts.
module bayes_stoch_engine
  import bayes_pkg::*;
#(
  parameter int                WORD_SIZE  = 8,
  parameter int                STREAM_LEN = 256,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = DEFAULT_SEED,
  localparam int               CNT_W      = $clog2(STREAM_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           word_sel,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [CNT_W-1:0]     num_count,
  output logic [CNT_W-1:0]     alt_count
);

  generate
    if (LFSR_SEED == '0) begin : g_bad_seed
      $error("bayes_stoch_engine: LFSR_SEED must be non-zero");
    end
    if (WORD_SIZE != 8) begin : g_bad_width
      $error("bayes_stoch_engine: only WORD_SIZE=8 is supported");
    end
    if (STREAM_LEN < 2 || STREAM_LEN > 65535) begin : g_bad_len
      $error("bayes_stoch_engine: STREAM_LEN out of range 2..65535");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STREAM_LEN);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(STREAM_LEN - 1);

  state_e state_q, state_d;

  logic [1:0]           fc_q, fc_d;
  logic [CNT_W-1:0]     rc_q, rc_d;
  logic [WORD_SIZE-1:0] prior_q, prior_d;
  logic [WORD_SIZE-1:0] lik_h_q, lik_h_d;
  logic [WORD_SIZE-1:0] lik_nh_q, lik_nh_d;
  logic [CNT_W-1:0]     num_count_q, num_count_d;
  logic [CNT_W-1:0]     alt_count_q, alt_count_d;

  logic              accept;
  logic              run_en;
  logic [LFSR_W-1:0] lfsr_q;
  logic              h_bit, e1_bit, e0_bit;

  assign accept = (state_q == IDLE) && start;
  assign run_en = (state_q == RUN);

  bayes_lfsr24 #(
    .RESET_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .seed (LFSR_SEED),
    .en   (run_en),
    .q    (lfsr_q)
  );

  assign h_bit  = lfsr_q[7:0]   < prior_q;
  assign e1_bit = lfsr_q[15:8]  < lik_h_q;
  assign e0_bit = lfsr_q[23:16] < lik_nh_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (fc_q == 2'd3) state_d = RUN;
      RUN:     if (rc_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs; word_sel saturates at the last operand so fc=3 re-reads it.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    word_sel = W_PRIOR;
    case (state_q)
      FETCH: begin
        busy = 1'b1;
        case (fc_q)
          2'd0:    word_sel = W_PRIOR;
          2'd1:    word_sel = W_LIK_H;
          default: word_sel = W_LIK_NH;
        endcase
      end
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // SRAM data lags word_sel by one cycle, hence capture at fc = index+1.
  always_comb begin
    fc_d        = fc_q;
    rc_d        = rc_q;
    prior_d     = prior_q;
    lik_h_d     = lik_h_q;
    lik_nh_d    = lik_nh_q;
    num_count_d = num_count_q;
    alt_count_d = alt_count_q;
    if (accept) begin
      fc_d        = 2'd0;
      num_count_d = '0;
      alt_count_d = '0;
    end
    if (state_q == FETCH) begin
      fc_d = fc_q + 2'd1;
      if (fc_q == W_PRIOR + 2'd1)  prior_d  = data_in;
      if (fc_q == W_LIK_H + 2'd1)  lik_h_d  = data_in;
      if (fc_q == W_LIK_NH + 2'd1) lik_nh_d = data_in;
      if (fc_q == 2'd3)            rc_d     = RUN_LAST;
    end
    if (run_en) begin
      if (rc_q != '0) rc_d = rc_q - CNT_W'(1);
      if (h_bit && e1_bit && (num_count_q != CNT_MAX)) begin
        num_count_d = num_count_q + CNT_W'(1);
      end
      if (!h_bit && e0_bit && (alt_count_q != CNT_MAX)) begin
        alt_count_d = alt_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fc_q        <= 2'd0;
      rc_q        <= '0;
      prior_q     <= '0;
      lik_h_q     <= '0;
      lik_nh_q    <= '0;
      num_count_q <= '0;
      alt_count_q <= '0;
    end else begin
      fc_q        <= fc_d;
      rc_q        <= rc_d;
      prior_q     <= prior_d;
      lik_h_q     <= lik_h_d;
      lik_nh_q    <= lik_nh_d;
      num_count_q <= num_count_d;
      alt_count_q <= alt_count_d;
    end
  end

  assign num_count = num_count_q;
  assign alt_count = alt_count_q;

endmodule

// File: tb/tb_bayes_stoch_engine.sv
// Directed self-checking bench for bayes_stoch_engine (default and STREAM_LEN=2).
module tb_bayes_stoch_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start2;
  logic       busy, done, busy2, done2;
  logic [1:0] ws, ws2;
  logic [7:0] din = 8'h00, din2 = 8'h00;
  logic [8:0] num, alt;
  logic [1:0] num2, alt2;
  logic [7:0] mem[4];
  logic [7:0] mem2[4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Registered SRAM models, one-cycle read latency
  always @(posedge clk) din  <= mem[ws];
  always @(posedge clk) din2 <= mem2[ws2];

  bayes_stoch_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .word_sel(ws), .data_in(din), .num_count(num), .alt_count(alt)
  );

  bayes_stoch_engine #(.STREAM_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .word_sel(ws2), .data_in(din2), .num_count(num2), .alt_count(alt2)
  );

  task automatic ref_model(input logic [7:0] p, input logic [7:0] lh, input logic [7:0] lnh,
                           input int len, output int rn, output int ra, output int n_ff);
    logic [23:0] s;
    logic h, e1, e0;
    s = 24'h5A3C96;
    rn = 0; ra = 0; n_ff = 0;
    for (int i = 0; i < len; i++) begin
      h  = s[7:0] < p;
      e1 = s[15:8] < lh;
      e0 = s[23:16] < lnh;
      if (h && e1) rn++;
      if (!h && e0) ra++;
      if (s[23:16] == 8'hFF) n_ff++;
      s = {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
    end
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  // Leaves the caller at the negedge of cycle 1 after the accepting edge.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int budget, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    set_mem(8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) mem2[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (ws !== 2'd0) begin n_fail++; $display("FAIL reset_word_sel got %0d want 0", ws); end
    n_checks++; if (num !== 9'd0) begin n_fail++; $display("FAIL reset_num got %0d want 0", num); end
    n_checks++; if (alt !== 9'd0) begin n_fail++; $display("FAIL reset_alt got %0d want 0", alt); end
    n_checks++; if (busy2 !== 1'b0 || num2 !== 2'd0) begin n_fail++; $display("FAIL reset_dut2 got busy=%b num=%0d want 0/0", busy2, num2); end
  endtask

  task automatic test_fetch_run();
    logic [1:0] exp_ws[4];
    int cyc, rn, ra, nff;
    exp_ws = '{2'd0, 2'd1, 2'd2, 2'd2};
    set_mem(8'hA5, 8'hCC, 8'h5A, 8'hF0);
    pulse_start();
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      n_checks++;
      if (ws !== exp_ws[c-1] || busy !== 1'b1) begin
        n_fail++; $display("FAIL fetch_word_sel cycle %0d got ws=%0d busy=%b want ws=%0d busy=1", c, ws, busy, exp_ws[c-1]);
      end
    end
    wait_done(4, 400, cyc);
    n_checks++; if (cyc != 261) begin n_fail++; $display("FAIL run_latency got %0d want 261", cyc); end
    n_checks++; if (dut.prior_q !== 8'hA5) begin n_fail++; $display("FAIL op_prior got %h want a5", dut.prior_q); end
    n_checks++; if (dut.lik_h_q !== 8'hCC) begin n_fail++; $display("FAIL op_lik_h got %h want cc", dut.lik_h_q); end
    n_checks++; if (dut.lik_nh_q !== 8'h5A) begin n_fail++; $display("FAIL op_lik_nh got %h want 5a", dut.lik_nh_q); end
    ref_model(8'hA5, 8'hCC, 8'h5A, 256, rn, ra, nff);
    n_checks++; if (int'(num) != rn) begin n_fail++; $display("FAIL run_num got %0d want %0d", num, rn); end
    n_checks++; if (int'(alt) != ra) begin n_fail++; $display("FAIL run_alt got %0d want %0d", alt, ra); end
    // Statistical bands only meaningful if the exact sequence lands inside them
    if (rn >= 116 && rn <= 146 && ra >= 22 && ra <= 42) begin
      n_checks++;
      if (num < 9'd116 || num > 9'd146 || alt < 9'd22 || alt > 9'd42) begin
        n_fail++; $display("FAIL run_bands got num=%0d alt=%0d want 131+-15 / 32+-10", num, alt);
      end
    end else begin
      $display("note: reference counts num=%0d alt=%0d fall outside sanity bands", rn, ra);
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got done=%b busy=%b want 0/0", done, busy); end
    n_checks++; if (int'(num) != rn) begin n_fail++; $display("FAIL count_hold got %0d want %0d", num, rn); end
  endtask

  task automatic test_reset_mid_run();
    int rn, ra, nff, dones;
    set_mem(8'hA5, 8'hCC, 8'h5A, 8'hF0);
    pulse_start();
    repeat (103) @(negedge clk);
    ref_model(8'hA5, 8'hCC, 8'h5A, 99, rn, ra, nff);
    n_checks++;
    if (int'(num) != rn || int'(alt) != ra) begin
      n_fail++; $display("FAIL midrun_counts got %0d/%0d want %0d/%0d", num, alt, rn, ra);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_busy_done got %b/%b want 0/0", busy, done); end
    n_checks++; if (ws !== 2'd0) begin n_fail++; $display("FAIL rst_word_sel got %0d want 0", ws); end
    n_checks++; if (num !== 9'd0 || alt !== 9'd0) begin n_fail++; $display("FAIL rst_counts got %0d/%0d want 0/0", num, alt); end
    n_checks++; if (dut.prior_q !== 8'h00 || dut.lik_h_q !== 8'h00 || dut.lik_nh_q !== 8'h00) begin
      n_fail++; $display("FAIL rst_operands got %h %h %h want 00 00 00", dut.prior_q, dut.lik_h_q, dut.lik_nh_q);
    end
    n_checks++; if (dut.u_lfsr.q_q !== 24'h5A3C96) begin n_fail++; $display("FAIL rst_lfsr got %h want 5a3c96", dut.u_lfsr.q_q); end
    dones = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rst_no_done got %0d active cycles want 0", dones); end
  endtask

  task automatic test_zero_prior();
    int cyc, rn, ra, nff;
    set_mem(8'h00, 8'hFF, 8'hFF, 8'h00);
    pulse_start();
    wait_done(1, 400, cyc);
    ref_model(8'h00, 8'hFF, 8'hFF, 256, rn, ra, nff);
    n_checks++; if (cyc != 261) begin n_fail++; $display("FAIL zp_latency got %0d want 261", cyc); end
    n_checks++; if (num !== 9'd0) begin n_fail++; $display("FAIL zp_num got %0d want 0", num); end
    n_checks++; if (int'(alt) != 256 - nff) begin n_fail++; $display("FAIL zp_alt got %0d want %0d", alt, 256 - nff); end
    n_checks++; if (alt < 9'd250) begin n_fail++; $display("FAIL zp_alt_min got %0d want >=250", alt); end
  endtask

  task automatic test_start_held();
    int cyc, rn, ra, nff;
    set_mem(8'hA5, 8'hCC, 8'h5A, 8'hF0);
    ref_model(8'hA5, 8'hCC, 8'h5A, 256, rn, ra, nff);
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    wait_done(1, 400, cyc);
    n_checks++; if (cyc != 261) begin n_fail++; $display("FAIL held_first_done got %0d want 261", cyc); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL held_idle got busy=%b done=%b want 0/0", busy, done); end
    n_checks++; if (int'(num) != rn) begin n_fail++; $display("FAIL held_hold got %0d want %0d", num, rn); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || ws !== 2'd0) begin n_fail++; $display("FAIL held_reaccept got busy=%b ws=%0d want 1/0", busy, ws); end
    n_checks++; if (num !== 9'd0 || alt !== 9'd0) begin n_fail++; $display("FAIL held_clear got %0d/%0d want 0/0", num, alt); end
    start = 1'b0;
    wait_done(263, 700, cyc);
    n_checks++; if (cyc != 523) begin n_fail++; $display("FAIL held_second_done got %0d want 523", cyc); end
    n_checks++; if (int'(num) != rn || int'(alt) != ra) begin n_fail++; $display("FAIL held_counts got %0d/%0d want %0d/%0d", num, alt, rn, ra); end
  endtask

  task automatic test_short();
    int cyc, rn, ra, nff;
    for (int i = 0; i < 4; i++) mem2[i] = 8'hFF;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 1;
    while (done2 !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (done2 !== 1'b1) cyc = -1;
    ref_model(8'hFF, 8'hFF, 8'hFF, 2, rn, ra, nff);
    n_checks++; if (cyc != 7) begin n_fail++; $display("FAIL short_latency got %0d want 7", cyc); end
    n_checks++; if (int'(num2) != rn || int'(alt2) != ra) begin n_fail++; $display("FAIL short_counts got %0d/%0d want %0d/%0d", num2, alt2, rn, ra); end
    n_checks++; if (int'(num2) + int'(alt2) > 2) begin n_fail++; $display("FAIL short_sum got %0d want <=2", int'(num2) + int'(alt2)); end
  endtask

  initial begin
    test_reset();
    test_fetch_run();
    test_reset_mid_run();
    test_zero_prior();
    test_start_held();
    test_short();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
